// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Execute-stage request/response bundle for the RV32M
//                multiply/divide unit.
//                master : pipeline side (drives request, observes status)
//                slave  : mul_div_unit side
//  Signals     : startE, funct3E[2:0], rdata1E[31:0], rdata2E[31:0], killE
//                (request), stall_req, busy, done, result[31:0] (response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
  logic        startE;
  logic [2:0]  funct3E;
  logic [31:0] rdata1E;
  logic [31:0] rdata2E;
  logic        killE;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output startE, funct3E, rdata1E, rdata2E, killE,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  startE, funct3E, rdata1E, rdata2E, killE,
    output stall_req, busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide unit. One bit per cycle in
//                CALC (shift-add multiply, restoring divide on magnitudes),
//                sign correction and word select in FIX, one-cycle done
//                pulse in DONE. Start-to-done latency is 34 cycles.
//  Ports       : clk          - rising-edge clock
//                rst          - asynchronous active-low reset
//                bus (slave)  - startE/funct3E/rdata1E/rdata2E/killE in,
//                               stall_req (comb), busy/done/result (regs) out
//  Options     : M_EARLY_OUT_EN - when defined, divide-by-zero, signed
//                overflow and multiply-by-zero finish straight from IDLE
//                with done in the cycle after the start edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'd31;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] opa_q;     // multiplicand magnitude (MUL*) or divisor magnitude (DIV*/REM*)
  logic [63:0] acc_q;     // product, or {remainder, quotient} while dividing
  logic        a_neg_q;
  logic        b_neg_q;
  logic        dz_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  // Operand conditioning at accept time
  logic        in_is_div;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;
  logic        early_hit;
  logic [31:0] early_res;

  // Datapath
  logic [32:0] mul_sum;
  logic [32:0] div_tmp;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] acc_d;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result_d;

  always_comb begin
    in_is_div = bus.funct3E[2];
    // rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM
    in_a_neg  = bus.rdata1E[31] &
                (in_is_div ? ~bus.funct3E[0] : (bus.funct3E[1:0] != 2'b11));
    in_b_neg  = bus.rdata2E[31] &
                (in_is_div ? ~bus.funct3E[0] : ~bus.funct3E[1]);
    in_a_mag  = in_a_neg ? (~bus.rdata1E + 32'd1) : bus.rdata1E;
    in_b_mag  = in_b_neg ? (~bus.rdata2E + 32'd1) : bus.rdata2E;

`ifdef M_EARLY_OUT_EN
    early_hit = 1'b0;
    early_res = 32'h0000_0000;
    if (in_is_div) begin
      if (bus.rdata2E == 32'h0000_0000) begin
        early_hit = 1'b1;
        early_res = bus.funct3E[1] ? bus.rdata1E : 32'hFFFF_FFFF;
      end else if (!bus.funct3E[0] && bus.rdata1E == 32'h8000_0000 &&
                   bus.rdata2E == 32'hFFFF_FFFF) begin
        early_hit = 1'b1;
        early_res = bus.funct3E[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
    end else if (bus.rdata1E == 32'h0000_0000 || bus.rdata2E == 32'h0000_0000) begin
      early_hit = 1'b1;
      early_res = 32'h0000_0000;
    end
`else
    early_hit = 1'b0;
    early_res = 32'h0000_0000;
`endif
  end

  always_comb begin
    // Multiply: add multiplicand into the upper half when the LSB of the
    // multiplier (held in the lower half) is set, then shift right.
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    // Divide: shift next dividend bit into the partial remainder and try
    // the subtraction. The partial remainder is always below the divisor,
    // so the difference fits in 32 bits whenever div_ge holds.
    div_tmp = {acc_q[63:32], acc_q[31]};
    div_ge  = (div_tmp >= {1'b0, opa_q});
    div_sub = div_tmp[31:0] - opa_q;
    if (op_q[2]) begin
      acc_d = {(div_ge ? div_sub : div_tmp[31:0]), acc_q[30:0], div_ge};
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end

    prod_fix = (a_neg_q ^ b_neg_q) ? (~acc_q + 64'd1) : acc_q;
    // With a zero divisor the remainder half ends up holding the dividend
    // magnitude, so only the quotient needs an override.
    quo_fix  = dz_q ? 32'hFFFF_FFFF :
               ((a_neg_q ^ b_neg_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
    rem_fix  = a_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    case (op_q)
      3'b000:                 result_d = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: result_d = prod_fix[63:32];
      3'b100, 3'b101:         result_d = quo_fix;
      default:                result_d = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      opa_q    <= 32'd0;
      acc_q    <= 64'd0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (bus.killE) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.startE) begin
            op_q    <= bus.funct3E;
            a_neg_q <= in_a_neg;
            b_neg_q <= in_b_neg;
            dz_q    <= (bus.rdata2E == 32'd0);
            cnt_q   <= 5'd0;
            if (in_is_div) begin
              opa_q <= in_b_mag;
              acc_q <= {32'd0, in_a_mag};
            end else begin
              opa_q <= in_a_mag;
              acc_q <= {32'd0, in_b_mag};
            end
            if (early_hit) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= early_res;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_BIT) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= result_d;
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_req = ((state_q == S_IDLE) && bus.startE) || busy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule
`default_nettype wire
